// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package inst_mem_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory word-write port of the boot loader.
interface inst_mem_loader_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // Master is the host/memory side; slave is the loader.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/inst_mem_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; first byte lands in [31:24].
module inst_mem_loader_byte_packer
  import inst_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);

  logic [23:0]     shift_q, shift_d;
  logic [IdxW-1:0] idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (accept_i) begin
      shift_d = {shift_q[15:0], byte_i};
      idx_d   = idx_q + IdxW'(1);
    end
  end

  // The word is presented in the same cycle its last byte is accepted.
  assign word_o          = {shift_q, byte_i};
  assign word_complete_o = accept_i && (idx_q == IdxW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: packs a byte stream into words and writes them from a base address.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  word_len_i,
  inst_mem_loader_if.slave  bus,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       checksum_o
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [31:0]       checksum_q, checksum_d;

  logic        start_acc;
  logic        byte_acc;
  logic [31:0] packed_word;
  logic        word_complete;

  assign start_acc = (state_q == StIdle) && start_i;
  assign byte_acc  = (state_q == StLoad) && bus.in_valid;

  inst_mem_loader_byte_packer u_packer (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (start_acc),
    .accept_i        (byte_acc),
    .byte_i          (bus.in_data),
    .word_o          (packed_word),
    .word_complete_o (word_complete)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    addr_d     = addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    checksum_d = checksum_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d      = word_len_i;
          addr_d     = base_addr_i;
          word_idx_d = '0;
          checksum_d = '0;
          state_d    = (word_len_i == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (word_complete) begin
          wr_addr_d = addr_q;
          wr_data_d = packed_word;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        checksum_d = checksum_q ^ wr_data_q;
        // Address arithmetic wraps naturally at 2^ADDR_W.
        addr_d     = addr_q + ADDR_W'(BYTES_PER_WORD);
        word_idx_d = word_idx_q + LEN_W'(1);
        state_d    = (word_idx_d == len_q) ? StDone : StLoad;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.in_ready = (state_q == StLoad);
  assign bus.wr_en    = (state_q == StWrite);
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign checksum_o   = checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      addr_q     <= addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      checksum_q <= checksum_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized self-checking bench for inst_mem_loader against a word-list reference model.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_len;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wq[$];

  always #5 clk = ~clk;

  inst_mem_loader_if #(.ADDR_W(32)) bus ();

  inst_mem_loader #(
    .ADDR_W (32),
    .LEN_W  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .word_len_i  (word_len),
    .bus         (bus),
    .busy_o      (busy),
    .done_o      (done),
    .checksum_o  (checksum)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check_val({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    check_val({tag, "_wr_addr"}, bus.wr_addr, 32'd0);
    check_val({tag, "_wr_data"}, bus.wr_data, 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_checksum"}, checksum, 32'd0);
  endtask

  // Reference: word i goes to base+4*i, bytes sent MSB first, checksum is XOR of all words.
  task automatic run_load(input string tag, input logic [31:0] base, input int unsigned stall_pct,
                          input bit poke_start);
    int unsigned len = wq.size();
    logic [31:0] exp_ck = 32'd0;
    logic [31:0] w;
    int nw = 0;
    int bi = 0;
    int c = 1;
    int last_wr = -100;
    bit seen_done = 1'b0;
    bit poked = 1'b0;
    foreach (wq[i]) exp_ck ^= wq[i];

    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    word_len = 16'(len);
    @(negedge clk);
    start = 1'b0;
    base_addr = $urandom;
    word_len = 16'($urandom);
    check_val({tag, "_busy_t1"}, 32'(busy), 32'd1);
    check_val({tag, "_ready_t1"}, 32'(bus.in_ready), 32'(len > 0));

    while (!seen_done && c < 2000) begin
      if (bus.wr_en) begin
        check_val({tag, "_ready_in_write"}, 32'(bus.in_ready), 32'd0);
        if (nw < int'(len)) begin
          check_val({tag, "_wr_addr"}, bus.wr_addr, base + 32'(4 * nw));
          check_val({tag, "_wr_data"}, bus.wr_data, wq[nw]);
        end else begin
          check_val({tag, "_extra_write"}, 32'd1, 32'd0);
        end
        nw++;
        last_wr = c;
      end
      if (done) begin
        seen_done = 1'b1;
        check_val({tag, "_done_cycle"}, 32'(c), (len == 0) ? 32'd1 : 32'(last_wr + 1));
        check_val({tag, "_n_writes"}, 32'(nw), 32'(len));
        check_val({tag, "_busy_at_done"}, 32'(busy), 32'd1);
      end
      start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'($urandom);
      if (bi < int'(4 * len) && $urandom_range(99) >= stall_pct) begin
        w = wq[bi / 4];
        bus.in_valid = 1'b1;
        bus.in_data = w[31 - 8 * (bi % 4) -: 8];
      end
      if (bus.in_valid && bus.in_ready) bi++;
      if (poke_start && !poked && bi == 2) begin
        poked = 1'b1;
        start = 1'b1;
        base_addr = 32'hDEAD_0000;
        word_len = 16'd7;
      end
      c++;
      @(negedge clk);
    end
    if (!seen_done) check_val({tag, "_timeout"}, 32'd1, 32'd0);
    start = 1'b0;
    bus.in_valid = 1'b0;
    check_val({tag, "_busy_after"}, 32'(busy), 32'd0);
    check_val({tag, "_done_after"}, 32'(done), 32'd0);
    check_val({tag, "_checksum"}, checksum, exp_ck);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_len = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    wq = '{32'hE3A02103};
    run_load("single", 32'h0, 0, 1'b0);

    wq = '{32'hE3A02103, 32'hE0923002, 32'hE4803008};
    run_load("three", 32'h0, 0, 1'b0);

    wq = '{32'h1234_5678, 32'h9ABC_DEF0};
    run_load("stall", 32'h100, 50, 1'b0);

    wq.delete();
    run_load("zero_len", 32'h20, 0, 1'b0);

    wq = '{32'hCAFE_BABE, 32'h0BAD_F00D};
    run_load("ign_start", 32'h200, 20, 1'b1);

    // Abort two bytes into the first word of a load.
    wq = '{32'hA1B2_C3D4, 32'h5566_7788};
    @(negedge clk);
    start = 1'b1;
    base_addr = 32'h40;
    word_len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    w = wq[0];
    bus.in_valid = 1'b1;
    bus.in_data = w[31:24];
    @(negedge clk);
    bus.in_data = w[23:16];
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'($urandom);
      @(negedge clk);
      check_val("post_rst_no_write", 32'(bus.wr_en), 32'd0);
    end
    bus.in_valid = 1'b0;
    run_load("fresh", 32'h40, 10, 1'b0);

    wq = '{32'h1111_2222, 32'h3333_4444};
    run_load("wrap", 32'hFFFF_FFFC, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      wq.delete();
      for (int k = 0; k < int'($urandom_range(4, 1)); k++) wq.push_back($urandom);
      run_load("rand", {$urandom, 2'b00}, $urandom_range(70), r[0]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
